shift_add_mult_16bit: RTL and testbench

Sequential 16x16 unsigned shift-and-add multiplier built around the existing `cla_16bit` adder. It drives the adder's `a`/`b`/`cin` inputs and consumes its `s`/`cout` outputs once per cycle, producing a 32-bit product after 16 iterations. It is the first sequential datapath stage layered on the carry-lookahead adder. It exposes a simple start/busy/done handshake to the surrounding control.

---
 rtl/shift_add_mult_16bit_pkg.sv | 22 ++
 rtl/cla_16bit.sv | 50 +++++
 rtl/shift_add_mult_16bit.sv | 87 ++++++++
 tb/tb_shift_add_mult_16bit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_16bit_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package shift_add_mult_16bit_pkg;

  // Operand width, fixed to match cla_16bit
  localparam int unsigned Width = 16;

  // Counter value during the sixteenth (final) iteration
  localparam logic [4:0] IterLast = 5'd15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Addend for one iteration: the multiplicand when the current multiplier bit is set
  function automatic logic [Width-1:0] partial_addend(input logic [Width-1:0] mcand,
                                                      input logic             qbit);
    return qbit ? mcand : '0;
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a group-level lookahead.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Bit and group generate/propagate, group carries, then per-bit carries and sum
  always_comb begin
    g = a & b;
    p = a ^ b;

    for (int grp = 0; grp < 4; grp++) begin
      gg[grp] = g[4*grp+3]
              | (p[4*grp+3] & g[4*grp+2])
              | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
              | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
      gp[grp] = &p[4*grp +: 4];
    end

    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 0) begin
        c[i] = gc[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end

    s    = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/shift_add_mult_16bit.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one iteration per cycle through cla_16bit.
module shift_add_mult_16bit
  import shift_add_mult_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [Width-1:0]  a,
  input  logic [Width-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [2*Width-1:0] product
);

  state_e           state_q;
  logic [Width-1:0] m_q;
  logic [Width-1:0] acc_q;
  logic [Width-1:0] q_q;
  logic [4:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [Width-1:0] add_b;
  logic [Width-1:0] sum;
  logic             add_cout;

  assign add_b = partial_addend(m_q, q_q[0]);

  cla_16bit u_adder (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (add_cout)
  );

  // FSM, iteration counter and A/Q shift registers; busy and done are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          // Carry-out lands in A[15]; the sum LSB shifts into the top of Q
          acc_q <= {add_cout, sum[Width-1:1]};
          q_q   <= {sum[0], q_q[Width-1:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == IterLast) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_q, q_q};

endmodule

// File: tb/tb_shift_add_mult_16bit.sv
// Scoreboard bench for shift_add_mult_16bit: expected products and done cycles are queued at
// issue time and popped by an independent monitor whenever done is seen.
module tb_shift_add_mult_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  shift_add_mult_16bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Wait for the multiplier to be idle, pulse start, and queue the arithmetic result
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("issue_timeout", 32'd1, 32'd0);
      return;
    end
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.prod = 32'(x) * 32'(y);
    e.due  = cyc + 16;
    exp_q.push_back(e);
  endtask

  // Monitor: busy must track outstanding work; every done must match the oldest queued job
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    int n;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", product, 32'd0);
    #20;
    rst_n = 1'b1;

    // Directed operand pairs
    issue(16'h001F, 16'h000C);
    issue(16'hC61F, 16'h018C);
    issue(16'hFFFF, 16'hFFFF);
    issue(16'hFFFF, 16'h0000);
    issue(16'h0000, 16'hFFFF);
    issue(16'h8000, 16'h8000);

    // Start pulsed while busy with different operands must be ignored
    issue(16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(16'h0007, 16'h0009);

    // Randomized operands
    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom), 16'($urandom));
    end

    // Asynchronous reset in the middle of an operation
    issue(16'h1234, 16'h5678);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", product, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("idle_after_reset_busy", {31'd0, busy}, 32'd0);
    check("idle_after_reset_product", product, 32'd0);

    issue(16'hBEEF, 16'h0101);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
